bist_fail_logger: RTL

BIST_FAIL_LOGGER -- requirements
Module: bist_fail_logger

---
 rtl/bist_fail_logger_pkg.sv | 14 +
 rtl/bist_fail_logger_fifo.sv | 54 +++++
 rtl/bist_fail_logger.sv | 119 +++++++++++
 3 files changed

// File: rtl/bist_fail_logger_pkg.sv
// Shared types and default sizes for the BIST fail logger.
package bist_fail_logger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_LOG_DEPTH = 4;

endpackage

// File: rtl/bist_fail_logger_fifo.sv
// Synchronous fail-log FIFO; a push into a full log is taken only
// when a pop frees a slot on the same edge.
module fail_log_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push)
                wr_q <= wr_q + 1'b1;
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/bist_fail_logger.sv
// Collects BIST comparator results: fail count, first-fail address,
// a syndrome log and the final pass/fail verdict.
module bist_fail_logger
    import bist_fail_logger_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_valid,
    input  logic              cmp_fail,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_actual,
    input  logic [DATA_W-1:0] cmp_expected,
    input  logic              bist_done,
    input  logic              log_ready,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_syndrome,
    output logic [7:0]        error_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              log_overflow,
    output logic              result_valid,
    output logic              pass
);

    localparam int EW = ADDR_W + DATA_W;

    state_t            state_q;
    logic [7:0]        err_q;
    logic [7:0]        err_d;
    logic              ffv_q;
    logic [ADDR_W-1:0] ffa_q;
    logic              ovf_q;
    logic              rv_q;
    logic              pass_q;
    logic              fail_ev;
    logic              full;
    logic              empty;
    logic [EW-1:0]     head;

    assign fail_ev = (state_q == ARMED) && cmp_valid && cmp_fail && !start;

    fail_log_fifo #(
        .W     (EW),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .push  (fail_ev),
        .pop   (log_ready),
        .din   ({cmp_addr, cmp_actual ^ cmp_expected}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        err_d = err_q;
        if (fail_ev && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    // Start from any state restarts the sweep and wipes all results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else if (start) begin
            state_q <= ARMED;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    err_q <= err_d;
                    if (fail_ev && !ffv_q) begin
                        ffv_q <= 1'b1;
                        ffa_q <= cmp_addr;
                    end
                    if (fail_ev && full && !log_ready)
                        ovf_q <= 1'b1;
                    if (bist_done) begin
                        state_q <= REPORT;
                        rv_q    <= 1'b1;
                        pass_q  <= (err_d == 8'd0);
                    end
                end
                IDLE, REPORT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign log_valid        = !empty;
    assign log_addr         = empty ? '0 : head[EW-1:DATA_W];
    assign log_syndrome     = empty ? '0 : head[DATA_W-1:0];
    assign error_count      = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_addr  = ffa_q;
    assign log_overflow     = ovf_q;
    assign result_valid     = rv_q;
    assign pass             = pass_q;

endmodule
